// File: rtl/reg_scoreboard_if.sv
// Issue/retire bus between decode, writeback and the register write-pending scoreboard.
interface reg_scoreboard_if #(
    parameter int unsigned NREGS = 20,
    parameter int unsigned AW    = 5
);
    logic             issue_valid;
    logic [AW-1:0]    issue_rs1;
    logic [AW-1:0]    issue_rs2;
    logic             issue_rs1_used;
    logic             issue_rs2_used;
    logic [AW-1:0]    issue_rd;
    logic             issue_rd_we;
    logic             issue_ready;
    logic             wb_we;
    logic [AW-1:0]    wb_rd;
    logic             flush;
    logic [NREGS-1:0] busy_mask;
    logic [7:0]       inflight_cnt;
    logic [15:0]      stall_cnt;
    logic             wb_err;

    modport master (
        output issue_valid, issue_rs1, issue_rs2, issue_rs1_used, issue_rs2_used,
               issue_rd, issue_rd_we, wb_we, wb_rd, flush,
        input  issue_ready, busy_mask, inflight_cnt, stall_cnt, wb_err
    );

    modport slave (
        input  issue_valid, issue_rs1, issue_rs2, issue_rs1_used, issue_rs2_used,
               issue_rd, issue_rd_we, wb_we, wb_rd, flush,
        output issue_ready, busy_mask, inflight_cnt, stall_cnt, wb_err
    );
endinterface

// File: rtl/reg_scoreboard.sv
// Write-pending scoreboard: per-register in-flight write counters, RAW/WAW-saturation
// issue stall, retire bookkeeping and stall/error statistics.
module reg_scoreboard #(
    parameter int unsigned NREGS  = 20,
    parameter int unsigned AW     = 5,
    parameter int unsigned CW     = 2,
    parameter int unsigned PC_REG = 19
) (
    input logic            clk,
    input logic            reset,
    reg_scoreboard_if.slave sb
);
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam int unsigned   ICW     = 8;
    localparam int unsigned   SCW     = 16;

    logic [CW-1:0]    cnt_q [NREGS];
    logic [CW-1:0]    cnt_d [NREGS];
    logic [NREGS-1:0] inc_vec;
    logic [NREGS-1:0] dec_vec;
    logic [NREGS-1:0] busy_q, busy_d;
    logic [ICW-1:0]   infl_q, infl_d;
    logic [SCW-1:0]   stall_q;
    logic             wb_err_q;
    logic             err_set;
    logic             hazard;
    logic             fire;

    // L0 and PC are never written by the register file, nor is anything past NREGS.
    function automatic logic is_tracked(input int unsigned r);
        return (r != 0) && (r != PC_REG) && (r < NREGS);
    endfunction

    // RAW on any used source, or WAW when the destination counter is full.
    always_comb begin
        hazard = 1'b0;
        for (int unsigned r = 0; r < NREGS; r++) begin
            if (is_tracked(r) && cnt_q[r] != '0) begin
                if (sb.issue_rs1_used && sb.issue_rs1 == AW'(r)) hazard = 1'b1;
                if (sb.issue_rs2_used && sb.issue_rs2 == AW'(r)) hazard = 1'b1;
            end
            if (is_tracked(r) && cnt_q[r] == CNT_MAX &&
                sb.issue_rd_we && sb.issue_rd == AW'(r)) hazard = 1'b1;
        end
    end

    assign sb.issue_ready = !sb.flush && !hazard;
    assign fire           = sb.issue_valid && sb.issue_ready;

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int unsigned r = 0; r < NREGS; r++) begin
            inc_vec[r] = fire && sb.issue_rd_we && sb.issue_rd == AW'(r);
            dec_vec[r] = sb.wb_we && sb.wb_rd == AW'(r);
        end
    end

    // Flush wins over both issue and retire, and suppresses the retire error.
    always_comb begin
        err_set = 1'b0;
        busy_d  = '0;
        infl_d  = '0;
        for (int unsigned r = 0; r < NREGS; r++) begin
            cnt_d[r] = cnt_q[r];
            if (sb.flush) begin
                cnt_d[r] = '0;
            end else if (is_tracked(r)) begin
                if (inc_vec[r] && !dec_vec[r]) begin
                    cnt_d[r] = cnt_q[r] + CW'(1);
                end else if (dec_vec[r] && !inc_vec[r]) begin
                    if (cnt_q[r] != '0) cnt_d[r] = cnt_q[r] - CW'(1);
                    else                err_set  = 1'b1;
                end
            end
            busy_d[r] = cnt_d[r] != '0;
            infl_d    = infl_d + ICW'(cnt_d[r]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned r = 0; r < NREGS; r++) cnt_q[r] <= '0;
            busy_q   <= '0;
            infl_q   <= '0;
            stall_q  <= '0;
            wb_err_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            infl_q   <= infl_d;
            wb_err_q <= wb_err_q | err_set;
            if (sb.issue_valid && !sb.issue_ready && stall_q != '1)
                stall_q <= stall_q + SCW'(1);
        end
    end

    assign sb.busy_mask    = busy_q;
    assign sb.inflight_cnt = infl_q;
    assign sb.stall_cnt    = stall_q;
    assign sb.wb_err       = wb_err_q;
endmodule

// File: tb/tb_reg_scoreboard.sv
// Bench for reg_scoreboard: directed vector table, async reset sequence, then
// random traffic against a counter-array reference model.
module tb_reg_scoreboard;
    logic clk;
    logic reset;

    reg_scoreboard_if #(.NREGS(20), .AW(5)) bus ();

    reg_scoreboard #(.NREGS(20), .AW(5), .CW(2), .PC_REG(19)) dut (
        .clk  (clk),
        .reset(reset),
        .sb   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int v, rs1, u1, rs2, u2, rd, we, wbwe, wbrd, fl;
        int e_ready, e_busy, e_infl, e_err, e_stall;
    } vec_t;

    int n_chk;
    int n_fail;
    int m_cnt [32];
    int m_err;
    int m_stall;
    vec_t tbl [$];

    task automatic chk(input string nm, input int idx, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0d (0x%0h) expected %0d (0x%0h)", nm, idx, act, act, exp, exp);
        end
    endtask

    function automatic vec_t mk(int v, int rs1, int u1, int rs2, int u2, int rd, int we,
                                int wbwe, int wbrd, int fl, int er, int eb, int ei, int ee, int es);
        vec_t t;
        t.v = v; t.rs1 = rs1; t.u1 = u1; t.rs2 = rs2; t.u2 = u2; t.rd = rd; t.we = we;
        t.wbwe = wbwe; t.wbrd = wbrd; t.fl = fl;
        t.e_ready = er; t.e_busy = eb; t.e_infl = ei; t.e_err = ee; t.e_stall = es;
        return t;
    endfunction

    function automatic bit m_tracked(int r);
        return r != 0 && r != 19 && r < 20;
    endfunction

    function automatic bit m_ready(vec_t t);
        bit hz;
        hz = (t.u1 != 0 && m_tracked(t.rs1) && m_cnt[t.rs1] != 0) ||
             (t.u2 != 0 && m_tracked(t.rs2) && m_cnt[t.rs2] != 0) ||
             (t.we != 0 && m_tracked(t.rd) && m_cnt[t.rd] == 3);
        return t.fl == 0 && !hz;
    endfunction

    function automatic int m_busy();
        int b = 0;
        for (int r = 0; r < 20; r++) if (m_cnt[r] != 0) b |= (1 << r);
        return b;
    endfunction

    function automatic int m_infl();
        int s = 0;
        for (int r = 0; r < 32; r++) s += m_cnt[r];
        return s;
    endfunction

    task automatic m_reset();
        for (int r = 0; r < 32; r++) m_cnt[r] = 0;
        m_err = 0;
        m_stall = 0;
    endtask

    task automatic m_update(vec_t t, bit rdy);
        bit fire = (t.v != 0) && rdy;
        if (t.v != 0 && !rdy && m_stall < 65535) m_stall++;
        if (t.fl != 0) begin
            for (int r = 0; r < 32; r++) m_cnt[r] = 0;
        end else begin
            bit inc = fire && t.we != 0 && m_tracked(t.rd);
            bit dec = t.wbwe != 0 && m_tracked(t.wbrd);
            if (inc && dec && t.rd == t.wbrd) begin
                // issue and retire to the same register cancel out
            end else begin
                if (inc) m_cnt[t.rd]++;
                if (dec) begin
                    if (m_cnt[t.wbrd] > 0) m_cnt[t.wbrd]--;
                    else m_err = 1;
                end
            end
        end
    endtask

    task automatic drive(vec_t t);
        bus.issue_valid    = t.v[0];
        bus.issue_rs1      = 5'(t.rs1);
        bus.issue_rs1_used = t.u1[0];
        bus.issue_rs2      = 5'(t.rs2);
        bus.issue_rs2_used = t.u2[0];
        bus.issue_rd       = 5'(t.rd);
        bus.issue_rd_we    = t.we[0];
        bus.wb_we          = t.wbwe[0];
        bus.wb_rd          = 5'(t.wbrd);
        bus.flush          = t.fl[0];
    endtask

    task automatic apply(input vec_t t, input bit use_exp, input int idx);
        bit rdy;
        @(negedge clk);
        drive(t);
        #1;
        rdy = m_ready(t);
        chk("ready_model", idx, int'(bus.issue_ready), int'(rdy));
        if (use_exp) chk("ready_tbl", idx, int'(bus.issue_ready), t.e_ready);
        m_update(t, rdy);
        @(posedge clk);
        #1;
        chk("busy_model",  idx, int'(bus.busy_mask),    m_busy());
        chk("infl_model",  idx, int'(bus.inflight_cnt), m_infl());
        chk("stall_model", idx, int'(bus.stall_cnt),    m_stall);
        chk("err_model",   idx, int'(bus.wb_err),       m_err);
        if (use_exp) begin
            chk("busy_tbl",  idx, int'(bus.busy_mask),    t.e_busy);
            chk("infl_tbl",  idx, int'(bus.inflight_cnt), t.e_infl);
            chk("stall_tbl", idx, int'(bus.stall_cnt),    t.e_stall);
            chk("err_tbl",   idx, int'(bus.wb_err),       t.e_err);
        end
    endtask

    task automatic check_zero_outputs(input string nm);
        chk({nm, "_busy"},  0, int'(bus.busy_mask),    0);
        chk({nm, "_infl"},  0, int'(bus.inflight_cnt), 0);
        chk({nm, "_stall"}, 0, int'(bus.stall_cnt),    0);
        chk({nm, "_err"},   0, int'(bus.wb_err),       0);
        chk({nm, "_ready"}, 0, int'(bus.issue_ready),  1);
    endtask

    initial begin
        vec_t idle, t;
        n_chk = 0;
        n_fail = 0;
        m_reset();
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        drive(idle);
        #12;
        check_zero_outputs("reset");
        @(negedge clk);
        reset = 1'b0;

        //          v rs1 u1 rs2 u2 rd we wbwe wbrd fl  rdy busy                 infl err stall
        tbl.push_back(mk(1, 0, 0, 0, 0,  5, 1, 0, 0, 0,  1, 1<<5,                1, 0, 0));
        tbl.push_back(mk(1, 5, 1, 0, 0,  0, 0, 0, 0, 0,  0, 1<<5,                1, 0, 1));
        tbl.push_back(mk(1, 5, 1, 0, 0,  0, 0, 0, 0, 0,  0, 1<<5,                1, 0, 2));
        tbl.push_back(mk(1, 5, 1, 0, 0,  0, 0, 1, 5, 0,  0, 0,                   0, 0, 3));
        tbl.push_back(mk(1, 5, 1, 0, 0,  0, 0, 0, 0, 0,  1, 0,                   0, 0, 3));
        tbl.push_back(mk(1, 0, 0, 0, 0,  0, 1, 0, 0, 0,  1, 0,                   0, 0, 3));
        tbl.push_back(mk(1, 0, 0, 0, 0, 19, 1, 0, 0, 0,  1, 0,                   0, 0, 3));
        tbl.push_back(mk(1, 0, 1,19, 1,  0, 0, 0, 0, 0,  1, 0,                   0, 0, 3));
        tbl.push_back(mk(0, 0, 0, 0, 0,  0, 0, 1,19, 0,  1, 0,                   0, 0, 3));
        tbl.push_back(mk(1, 0, 0, 0, 0,  7, 1, 0, 0, 0,  1, 1<<7,                1, 0, 3));
        tbl.push_back(mk(1, 0, 0, 0, 0,  7, 1, 0, 0, 0,  1, 1<<7,                2, 0, 3));
        tbl.push_back(mk(1, 0, 0, 0, 0,  7, 1, 0, 0, 0,  1, 1<<7,                3, 0, 3));
        tbl.push_back(mk(1, 0, 0, 0, 0,  7, 1, 0, 0, 0,  0, 1<<7,                3, 0, 4));
        tbl.push_back(mk(1, 0, 0, 0, 0,  8, 1, 0, 0, 0,  1, (1<<7)|(1<<8),       4, 0, 4));
        tbl.push_back(mk(1, 0, 0, 0, 0,  7, 1, 1, 7, 0,  0, (1<<7)|(1<<8),       3, 0, 5));
        tbl.push_back(mk(1, 0, 0, 0, 0,  7, 1, 0, 0, 0,  1, (1<<7)|(1<<8),       4, 0, 5));
        tbl.push_back(mk(0, 0, 0, 0, 0,  0, 0, 1, 7, 0,  1, (1<<7)|(1<<8),       3, 0, 5));
        tbl.push_back(mk(0, 0, 0, 0, 0,  0, 0, 1, 7, 0,  1, (1<<7)|(1<<8),       2, 0, 5));
        tbl.push_back(mk(0, 0, 0, 0, 0,  0, 0, 1, 7, 0,  1, 1<<8,                1, 0, 5));
        tbl.push_back(mk(0, 0, 0, 0, 0,  0, 0, 1, 8, 0,  1, 0,                   0, 0, 5));
        tbl.push_back(mk(1, 0, 0, 0, 0,  3, 1, 0, 0, 0,  1, 1<<3,                1, 0, 5));
        tbl.push_back(mk(1, 0, 0, 0, 0,  3, 1, 1, 3, 0,  1, 1<<3,                1, 0, 5));
        tbl.push_back(mk(0, 0, 0, 0, 0,  0, 0, 1, 3, 0,  1, 0,                   0, 0, 5));
        tbl.push_back(mk(1, 0, 0, 0, 0,  4, 1, 0, 0, 0,  1, 1<<4,                1, 0, 5));
        tbl.push_back(mk(1, 0, 0, 0, 0,  4, 1, 0, 0, 0,  1, 1<<4,                2, 0, 5));
        tbl.push_back(mk(1, 0, 0, 0, 0,  9, 1, 0, 0, 0,  1, (1<<4)|(1<<9),       3, 0, 5));
        tbl.push_back(mk(1, 0, 0, 0, 0,  4, 1, 1, 9, 1,  0, 0,                   0, 0, 6));
        tbl.push_back(mk(0, 0, 0, 0, 0,  0, 0, 1,12, 0,  1, 0,                   0, 1, 6));
        tbl.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  1, 0,                   0, 1, 6));

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], 1'b1, i);

        // Asynchronous reset in the middle of a low phase clears everything at once.
        @(negedge clk);
        drive(idle);
        #2 reset = 1'b1;
        #1;
        check_zero_outputs("async_reset");
        m_reset();
        @(negedge clk);
        reset = 1'b0;

        // Random traffic; retires mostly target registers that have writes pending.
        for (int i = 0; i < 600; i++) begin
            int pend [$];
            t = idle;
            t.v    = int'($urandom_range(0, 3) != 0);
            t.rs1  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(20, 31)) : int'($urandom_range(0, 8));
            t.rs2  = int'($urandom_range(0, 8));
            t.u1   = int'($urandom_range(0, 2) == 0);
            t.u2   = int'($urandom_range(0, 3) == 0);
            t.rd   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(17, 31)) : int'($urandom_range(0, 6));
            t.we   = int'($urandom_range(0, 3) != 0);
            t.fl   = int'($urandom_range(0, 40) == 0);
            for (int r = 0; r < 20; r++) if (m_cnt[r] != 0) pend.push_back(r);
            t.wbwe = int'($urandom_range(0, 2) != 0);
            if (pend.size() != 0 && $urandom_range(0, 15) != 0)
                t.wbrd = pend[$urandom_range(0, pend.size() - 1)];
            else
                t.wbrd = int'($urandom_range(0, 31));
            apply(t, 1'b0, 1000 + i);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
